// File: rtl/sequential_alu.sv
// sequential_alu: registered ALU with binary opcode, logical shifts, an
// iterative shift-add multiplier, full status flags and valid/ready on both
// sides. One operation in flight at a time.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready request handshake (in_ready high only in IDLE)
//   opcode, in1, in2    operation and operands (in2 low bits = shift amount)
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   result, result_hi   result (MUL: low / high product halves, else hi=0)
//   carry, overflow, zero, negative, illegal   status flags
module sequential_alu #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero,
  output logic                  negative,
  output logic                  illegal
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_XOR = 4'd4, OP_INV = 4'd5,
                         OP_CLR = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8,
                         OP_MUL = 4'd9;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [W-1:0]   result_q, result_hi_q;
  logic           carry_q, overflow_q, zero_q, negative_q, illegal_q;
  logic [2*W-1:0] acc_q, mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept, mul_last;
  assign accept   = (state_q == S_IDLE) && in_valid;
  assign mul_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  // ---------------- single-cycle datapath ----------------
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [W:0]   sum, diff, shl, shr;
  logic [W-1:0] res_d;
  logic         carry_d, ovf_d, ill_d;

  assign shamt = in2[SHAMT_WIDTH-1:0];
  assign sum   = {1'b0, in1} + {1'b0, in2};
  assign diff  = {1'b0, in1} - {1'b0, in2};   // diff[W] is the borrow
  assign shl   = {1'b0, in1} << shamt;        // shl[W] = last bit out
  assign shr   = {in1, 1'b0} >> shamt;        // shr[0] = last bit out

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_d   = sum[W-1:0];
        carry_d = sum[W];
        ovf_d   = (in1[W-1] == in2[W-1]) && (sum[W-1] != in1[W-1]);
      end
      OP_SUB: begin
        res_d   = diff[W-1:0];
        carry_d = diff[W];
        ovf_d   = (in1[W-1] != in2[W-1]) && (diff[W-1] != in1[W-1]);
      end
      OP_AND: res_d = in1 & in2;
      OP_OR:  res_d = in1 | in2;
      OP_XOR: res_d = in1 ^ in2;
      OP_INV: res_d = ~in1;
      OP_CLR: res_d = '0;
      OP_SHL: begin
        res_d   = shl[W-1:0];
        carry_d = shl[W];
      end
      OP_SHR: begin
        res_d   = shr[W:1];
        carry_d = shr[0];
      end
      OP_MUL: res_d = '0;   // handled by the iterative path
      default: ill_d = 1'b1;
    endcase
  end

  // ---------------- multiplier step ----------------
  logic [2*W-1:0] acc_step;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = (opcode == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      illegal_q   <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        acc_q    <= '0;
        mcand_q  <= {{W{1'b0}}, in1};
        mplier_q <= in2;
        cnt_q    <= '0;
      end else begin
        result_q    <= res_d;
        result_hi_q <= '0;
        carry_q     <= carry_d;
        overflow_q  <= ovf_d;
        zero_q      <= (res_d == '0);
        negative_q  <= res_d[W-1];
        illegal_q   <= ill_d;
      end
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      // The last step's sum is the full product; publish it directly.
      if (mul_last) begin
        result_q    <= acc_step[W-1:0];
        result_hi_q <= acc_step[2*W-1:W];
        carry_q     <= (acc_step[2*W-1:W] != '0);
        overflow_q  <= 1'b0;
        zero_q      <= (acc_step == '0);
        negative_q  <= acc_step[2*W-1];
        illegal_q   <= 1'b0;
      end
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/sequential_alu.md
Name: sequential_alu

Overview:
Parametrised, registered successor to the combinational datapath ALU. Operation is selected by a binary opcode, not one-hot strobes, and logic operations are full-width. Adds shifts, an iterative shift-add multiplier, a full status-flag set and a valid/ready handshake on both sides. Sits between the register file and the accumulator/writeback path; the controller issues one operation and waits for the result.

Parameters:
DATA_WIDTH, 8, operand/result width in bits (>=2)
SHAMT_WIDTH, $clog2(DATA_WIDTH), width of shift-amount field taken from in2[SHAMT_WIDTH-1:0]

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request (high only in IDLE)
opcode  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV, 6 CLR, 7 SHL, 8 SHR, 9 MUL, 10-15 illegal
in1  input  DATA_WIDTH  operand A
in2  input  DATA_WIDTH  operand B / shift amount
out_valid  output  1  result registers valid
out_ready  input  1  consumer accepts result
result  output  DATA_WIDTH  result (MUL: low half)
result_hi  output  DATA_WIDTH  MUL high half; 0 for all other ops
carry  output  1  ADD carry-out / SUB borrow / last bit shifted out / MUL high half nonzero
overflow  output  1  signed two's-complement overflow (ADD/SUB only, else 0)
zero  output  1  result==0 (MUL: both halves 0)
negative  output  1  MSB of result (MUL: MSB of result_hi)
illegal  output  1  opcode 10-15 was issued

Behaviour:
- Reset: state IDLE; in_ready=1 (combinational from state); out_valid=0; result, result_hi, carry, overflow, zero, negative, illegal=0; multiplier counter/accumulator cleared.
- States: IDLE, MUL, DONE.
- IDLE: request accepted when in_valid&&in_ready; operands and opcode captured on that edge.
- Non-MUL op: result and flags computed from the inputs and registered on the accept edge; next state DONE. out_valid high the cycle after acceptance (latency 1).
- MUL: operands latched, then exactly DATA_WIDTH iterations, one multiplicand-shift/accumulate step per cycle in state MUL; counter reaches DATA_WIDTH-1, then DONE. out_valid high DATA_WIDTH+1 cycles after acceptance. Unsigned product; {result_hi,result}=in1*in2 (2*DATA_WIDTH bits, never truncated).
- DONE: out_valid=1; outputs held stable until out_ready=1; on that edge go to IDLE, out_valid=0. Result registers keep their value after handoff until the next op writes them. No request accepted in the same cycle as out handoff (in_ready=0 in DONE).
- ADD: {carry,result}=in1+in2; overflow=(in1[MSB]==in2[MSB])&&(result[MSB]!=in1[MSB]).
- SUB: result=in1-in2 mod 2^W; carry=1 iff in1<in2 unsigned; overflow=(in1[MSB]!=in2[MSB])&&(result[MSB]!=in1[MSB]).
- AND/OR/XOR full width; INV=~in1; CLR result 0. Carry/overflow=0 for all of these.
- SHL/SHR: logical, amount s=in2[SHAMT_WIDTH-1:0]; upper bits of in2 ignored; zero fill. carry=last bit shifted out; s=0 gives result=in1, carry=0.
- Illegal opcode: result=0, flags zero=1, illegal=1, latency 1; illegal cleared by the next legal op.
- zero/negative computed for every op from the registered result.
- in_valid held high while in_ready=0 has no effect; the request is not queued.
- rst asserted in any state, including mid-MUL or DONE with out_ready=0: next edge returns to reset values; partial product is discarded.

Test Plan:
- W=8. ADD 0xF0+0x20: result 0x10, carry 1, overflow 0, out_valid high 1 cycle after accept. ADD 0x7F+0x01: result 0x80, overflow 1, negative 1, carry 0.
- SUB 0x05-0x07: result 0xFE, carry 1, negative 1, overflow 0. SUB 0x80-0x01: result 0x7F, overflow 1. SUB 0x33-0x33: zero 1.
- MUL 0xFF*0xFF: out_valid exactly 9 cycles after accept; result_hi 0xFE, result 0x01, carry 1. MUL 0x0F*0x11: result 0xFF, result_hi 0x00, carry 0. MUL 0x00*0xAB: zero 1.
- SHL 0x81 by in2=0x09 (s=1): result 0x02, carry 1. SHR 0x01 by 1: result 0x00, carry 1, zero 1. SHL by s=0: result=in1, carry 0.
- Backpressure: ADD completes while out_ready=0 for 3 cycles; result/flags stable, in_ready=0, a second in_valid ignored. out_ready=1 gives IDLE next cycle. Opcode 12: result 0, illegal 1, zero 1.
- Reset mid-MUL (4th iteration): next cycle in_ready=1, out_valid=0, all outputs 0. A following ADD 0x01+0x01 gives 0x02 with correct latency.
